// File: rtl/rom_stream_if.sv
// Bundles the ROM read port and the outgoing valid/ready word stream of the ROM reader.
// The master side is the reader. The slave side is the ROM together with the stream consumer.
interface rom_stream_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_last;

  modport master (
    output rom_en, rom_addr, m_valid, m_data, m_addr, m_last,
    input  rom_data, m_ready
  );

  modport slave (
    input  rom_en, rom_addr, m_valid, m_data, m_addr, m_last,
    output rom_data, m_ready
  );
endinterface

// File: rtl/rom_stream_reader.sv
// Walks a wrapping ROM address range after a start pulse.
// Each ROM word goes out on a valid/ready stream, tagged with its address and a last-word flag.
//
// state  | meaning
// IDLE   | waiting for start; range latched on start
// STREAM | ROM port enabled, one fetch per cycle when output register is free
// DRAIN  | last word captured, waiting for consumer to take it
// DONE   | one-cycle done pulse, then back to IDLE
module rom_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  rom_stream_if.master      bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LEFT_ONE = (ADDR_W+1)'(1);

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] cur_q,      cur_d;
  logic [ADDR_W:0]   left_q,     left_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              m_valid_q,  m_valid_d;
  logic [DATA_W-1:0] m_data_q,   m_data_d;
  logic [ADDR_W-1:0] m_addr_q,   m_addr_d;
  logic              m_last_q,   m_last_d;

  logic [ADDR_W-1:0] range_diff;
  logic [ADDR_W:0]   range_len;
  logic              fetch;
  logic              handshake;

  // Modulo difference plus one; the extra bit lets a full wrap count all 2**ADDR_W words.
  assign range_diff = end_addr - start_addr;
  assign range_len  = {1'b0, range_diff} + LEFT_ONE;

  assign handshake = m_valid_q & bus.m_ready;
  assign fetch     = (state_q == S_STREAM) & (~m_valid_q | bus.m_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      left_q     <= '0;
      rom_addr_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_addr_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      left_q     <= left_d;
      rom_addr_q <= rom_addr_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_addr_q   <= m_addr_d;
      m_last_q   <= m_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    left_d     = left_q;
    rom_addr_d = rom_addr_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_addr_d   = m_addr_q;
    m_last_d   = m_last_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          cur_d   = start_addr;
          left_d  = range_len;
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        rom_addr_d = cur_q;
        if (abort) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = S_IDLE;
        end else if (fetch) begin
          m_data_d  = bus.rom_data;
          m_addr_d  = cur_q;
          m_last_d  = (left_q == LEFT_ONE);
          m_valid_d = 1'b1;
          cur_d     = cur_q + 1'b1;
          left_d    = left_q - LEFT_ONE;
          if (left_q == LEFT_ONE) state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Abort wins over a same-cycle handshake, so the pending word is dropped.
        if (abort || handshake) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = abort ? S_IDLE : S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // rom_addr follows cur live while streaming and holds the last fetched address otherwise.
  assign bus.rom_en   = (state_q == S_STREAM);
  assign bus.rom_addr = (state_q == S_STREAM) ? cur_q : rom_addr_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_last   = m_last_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Randomized bench for rom_stream_reader.
// A queue model of the expected word stream is filled per start and drained by a separate monitor.
module tb_rom_stream_reader;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] start_addr;
  logic [3:0] end_addr;
  logic       busy;
  logic       done;

  rom_stream_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  rom_stream_reader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  logic [7:0] rom_tbl [16];
  assign bus.rom_data = bus.rom_en ? rom_tbl[bus.rom_addr] : 8'h00;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   done_pending = 0;
  bit   stall_prev = 0;
  logic [7:0] hold_data;
  logic [3:0] hold_addr;
  logic       hold_last;
  int   ready_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  initial begin
    int ph;
    ph = 0;
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (ph % 3 == 0);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // Monitor: inputs are stable at the falling edge, so this sees exactly what the next rising edge will see.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev   = 0;
        done_pending = 0;
      end else begin
        if (done_pending) begin
          chk("done_pulse", 32'(done), 32'd1);
          done_pending = 0;
        end else if (done) begin
          chk("spurious_done", 32'(done), 32'd0);
        end
        if (stall_prev) begin
          chk("hold_valid", 32'(bus.m_valid), 32'd1);
          chk("hold_data", 32'(bus.m_data), 32'(hold_data));
          chk("hold_addr", 32'(bus.m_addr), 32'(hold_addr));
          chk("hold_last", 32'(bus.m_last), 32'(hold_last));
        end
        if (bus.m_valid && bus.m_last) chk("rom_en_drain", 32'(bus.rom_en), 32'd0);
        if (abort && busy) begin
          exp_q.delete();
          stall_prev = 0;
        end else begin
          if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_word", 32'(bus.m_addr), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("word_addr", 32'(bus.m_addr), 32'(e.addr));
              chk("word_data", 32'(bus.m_data), 32'(e.data));
              chk("word_last", 32'(bus.m_last), 32'(e.last));
              if (e.last) done_pending = 1;
            end
          end
          stall_prev = bus.m_valid && !bus.m_ready;
          hold_data  = bus.m_data;
          hold_addr  = bus.m_addr;
          hold_last  = bus.m_last;
        end
      end
    end
  end

  function automatic int burst_len(input logic [3:0] s, input logic [3:0] e);
    return ((int'(e) - int'(s) + 16) % 16) + 1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_en"},   32'(bus.rom_en),   32'd0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    chk({tag, "_m_valid"},  32'(bus.m_valid),  32'd0);
    chk({tag, "_m_data"},   32'(bus.m_data),   32'd0);
    chk({tag, "_m_addr"},   32'(bus.m_addr),   32'd0);
    chk({tag, "_m_last"},   32'(bus.m_last),   32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_done"},     32'(done),         32'd0);
  endtask

  // Drives a one-cycle start and loads the model with the expected words.
  task automatic issue_start(input logic [3:0] s, input logic [3:0] e);
    exp_t w;
    int   len;
    @(posedge clk);
    #1;
    chk("idle_before_start", 32'(busy), 32'd0);
    len = burst_len(s, e);
    for (int k = 0; k < len; k++) begin
      w.addr = 4'((int'(s) + k) % 16);
      w.data = rom_tbl[w.addr];
      w.last = (k == len - 1);
      exp_q.push_back(w);
    end
    start      = 1'b1;
    start_addr = s;
    end_addr   = e;
    @(posedge clk);
    #1;
    start      = 1'b0;
    start_addr = 4'($urandom);
    end_addr   = 4'($urandom);
  endtask

  // Counts falling edges after the start edge until done shows; a full-rate burst takes len+2.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc > 300) begin
        chk("done_timeout", 32'(cyc), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic run_burst(input logic [3:0] s, input logic [3:0] e, input int mode);
    int cyc;
    ready_mode = mode;
    issue_start(s, e);
    wait_done(cyc);
    if (mode == 0) chk("burst_cycles", 32'(cyc), 32'(burst_len(s, e) + 2));
  endtask

  initial begin
    int nv;
    for (int i = 0; i < 16; i++) rom_tbl[i] = 8'($urandom);
    rom_tbl[5] = 8'b1010_1110;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start_addr = '0;
    end_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_burst(4'd0, 4'd15, 0);
    run_burst(4'd14, 4'd1, 0);
    run_burst(4'd5, 4'd5, 0);
    run_burst(4'd0, 4'd3, 1);

    // Abort during the third valid cycle, then a fresh burst.
    ready_mode = 0;
    issue_start(4'd0, 4'd15);
    nv = 0;
    for (int i = 0; i < 50 && nv < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.m_valid) nv++;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_valid", 32'(bus.m_valid), 32'd0);
    chk("abort_busy",  32'(busy),        32'd0);
    chk("abort_rom_en", 32'(bus.rom_en), 32'd0);
    chk("abort_last",  32'(bus.m_last),  32'd0);
    repeat (3) @(posedge clk);
    run_burst(4'd2, 4'd3, 0);

    // Asynchronous reset mid-burst.
    ready_mode = 2;
    issue_start(4'd0, 4'd15);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy",  32'(busy),        32'd0);
    chk("post_rst_valid", 32'(bus.m_valid), 32'd0);

    // A start while busy must not re-latch the range.
    begin
      int cyc;
      ready_mode = 1;
      issue_start(4'd3, 4'd9);
      repeat (3) @(posedge clk);
      #1;
      start      = 1'b1;
      start_addr = 4'd10;
      end_addr   = 4'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(cyc);
    end

    run_burst(4'd7, 4'd6, 2);
    for (int i = 0; i < 12; i++) begin
      run_burst(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
